// File: rtl/cve2_obi_arbiter.sv
// Merges the instruction and data OBI masters onto one memory port; a small ID FIFO routes responses back.
// Optional CVE2_OBI_ARB_RR_EN: round-robin arbitration instead of fixed data priority.
module cve2_obi_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {
        MST_INSTR = 1'b0,
        MST_DATA  = 1'b1
    } mst_e;

    mst_e            ids [MaxOutstanding];
    logic [PtrW-1:0] wptr, rptr;
    logic [CntW-1:0] count;
    logic            locked;
    mst_e            locked_sel;
    mst_e            arb_sel, sel;
    logic            full, empty, grant, pop;
`ifdef CVE2_OBI_ARB_RR_EN
    mst_e            last_grant;
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        arb_sel = MST_INSTR;
        if (data_req_i && !instr_req_i) begin
            arb_sel = MST_DATA;
        end else if (data_req_i && instr_req_i) begin
`ifdef CVE2_OBI_ARB_RR_EN
            arb_sel = (last_grant == MST_DATA) ? MST_INSTR : MST_DATA;
`else
            arb_sel = MST_DATA;
`endif
        end
    end

    // A stalled request keeps its master until the slave grants it.
    assign sel   = locked ? locked_sel : arb_sel;
    assign full  = (count == CntW'(MaxOutstanding));
    assign empty = (count == '0);
    assign grant = mem_req_o & mem_gnt_i;
    assign pop   = rst_ni & mem_rvalid_i & ~empty;

    // Every output is forced low while reset is asserted.
    assign mem_req_o   = rst_ni & (instr_req_i | data_req_i) & ~full;
    assign mem_we_o    = rst_ni & (sel == MST_DATA) & data_we_i;
    assign mem_be_o    = !rst_ni ? 4'h0 : (sel == MST_DATA) ? data_be_i : 4'hF;
    assign mem_addr_o  = !rst_ni ? 32'h0 : (sel == MST_DATA) ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = (rst_ni && sel == MST_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = grant & (sel == MST_INSTR);
    assign data_gnt_o  = grant & (sel == MST_DATA);

    assign instr_rvalid_o = pop & (ids[rptr] == MST_INSTR);
    assign data_rvalid_o  = pop & (ids[rptr] == MST_DATA);
    assign instr_rdata_o  = rst_ni ? mem_rdata_i : 32'h0;
    assign data_rdata_o   = rst_ni ? mem_rdata_i : 32'h0;
    assign instr_err_o    = rst_ni & mem_err_i;
    assign data_err_o     = rst_ni & mem_err_i;

    always_ff @(posedge clk_i) begin
        if (grant) ids[wptr] <= sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            locked     <= 1'b0;
            locked_sel <= MST_INSTR;
        end else begin
            if (grant) wptr <= ptr_inc(wptr);
            if (pop)   rptr <= ptr_inc(rptr);
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            locked <= mem_req_o & ~mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) locked_sel <= sel;
        end
    end

`ifdef CVE2_OBI_ARB_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    last_grant <= MST_INSTR;
        else if (grant) last_grant <= sel;
    end
`endif

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Directed bench for cve2_obi_arbiter: reset, arbitration, lock, response ordering and FIFO limits.
module tb_cve2_obi_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        instr_req_i  = 1'b0; instr_addr_i = 32'h0;
        data_req_i   = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i  = 32'h0; data_wdata_i = 32'h0;
        mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
    endtask

    initial begin
        logic exp_data;
        logic prev_data;
        idle();
        // Reset with busy-looking inputs: everything must read 0.
        rst_ni = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h1234; mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF; mem_err_i = 1'b1; mem_gnt_i = 1'b1;
        #2;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_instr_gnt", instr_gnt_o, 0);
        chk("rst_instr_rvalid", instr_rvalid_o, 0);
        chk("rst_instr_rdata", instr_rdata_o, 0);
        chk("rst_data_err", data_err_o, 0);
        chk("rst_mem_be", mem_be_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        tick(); tick();
        idle();
        rst_ni = 1'b1;

        // Spurious response with empty FIFO, data still broadcast.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_0001; mem_err_i = 1'b1; #2;
        chk("spur_instr_rvalid", instr_rvalid_o, 0);
        chk("spur_data_rvalid", data_rvalid_o, 0);
        chk("bcast_data_rdata", data_rdata_o, 32'hA5A5_0001);
        chk("bcast_instr_err", instr_err_o, 1);
        tick(); idle();

        // Data-only write.
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3;
        data_addr_i = 32'h100; data_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1'b1; #2;
        chk("d_mem_req", mem_req_o, 1);
        chk("d_mem_be", mem_be_o, 4'h3);
        chk("d_mem_we", mem_we_o, 1);
        chk("d_mem_addr", mem_addr_o, 32'h100);
        chk("d_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("d_data_gnt", data_gnt_o, 1);
        chk("d_instr_gnt", instr_gnt_o, 0);
        tick(); idle();
        mem_rvalid_i = 1'b1; #2;
        chk("d_resp_data_rvalid", data_rvalid_o, 1);
        chk("d_resp_instr_rvalid", instr_rvalid_o, 0);
        tick(); idle();

        // Lock: instruction stalled three cycles, data arrives meanwhile.
        instr_req_i = 1'b1; instr_addr_i = 32'h2000; #2;
        chk("lk1_addr", mem_addr_o, 32'h2000);
        chk("lk1_be", mem_be_o, 4'hF);
        chk("lk1_gnt", instr_gnt_o, 0);
        tick();
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h1;
        data_addr_i = 32'h300; data_wdata_i = 32'h55; #2;
        chk("lk2_addr", mem_addr_o, 32'h2000);
        chk("lk2_we", mem_we_o, 0);
        chk("lk2_wdata", mem_wdata_o, 0);
        tick(); #2;
        chk("lk3_addr", mem_addr_o, 32'h2000);
        tick();
        mem_gnt_i = 1'b1; #2;
        chk("lk4_addr", mem_addr_o, 32'h2000);
        chk("lk4_instr_gnt", instr_gnt_o, 1);
        chk("lk4_data_gnt", data_gnt_o, 0);
        tick();
        instr_req_i = 1'b0; #2;
        chk("lk5_data_gnt", data_gnt_o, 1);
        chk("lk5_addr", mem_addr_o, 32'h300);
        tick();

        // Two outstanding: request blocked, even while a pop happens.
        instr_req_i = 1'b1; mem_rvalid_i = 1'b0; #2;
        chk("full_mem_req", mem_req_o, 0);
        chk("full_data_gnt", data_gnt_o, 0);
        mem_rvalid_i = 1'b1; #1;
        chk("fullpop_mem_req", mem_req_o, 0);
        chk("ord1_instr_rvalid", instr_rvalid_o, 1);
        chk("ord1_data_rvalid", data_rvalid_o, 0);
        tick(); idle();
        mem_rvalid_i = 1'b1; #2;
        chk("ord2_data_rvalid", data_rvalid_o, 1);
        chk("ord2_instr_rvalid", instr_rvalid_o, 0);
        tick(); #2;
        chk("ord3_empty_data_rvalid", data_rvalid_o, 0);
        chk("ord3_empty_instr_rvalid", instr_rvalid_o, 0);
        tick(); idle();

        // Simultaneous push and pop keeps occupancy; pointers wrap.
        instr_req_i = 1'b1; instr_addr_i = 32'h40; mem_gnt_i = 1'b1; #2;
        chk("pp0_instr_gnt", instr_gnt_o, 1);
        tick();
        mem_rvalid_i = 1'b1; #2;
        chk("pp1_instr_gnt", instr_gnt_o, 1);
        chk("pp1_instr_rvalid", instr_rvalid_o, 1);
        tick(); idle();
        data_req_i = 1'b1; data_addr_i = 32'h80; mem_gnt_i = 1'b1; #2;
        chk("pp2_mem_req", mem_req_o, 1);
        chk("pp2_data_gnt", data_gnt_o, 1);
        tick(); idle();
        instr_req_i = 1'b1; #2;
        chk("pp3_full_mem_req", mem_req_o, 0);
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1; #1;
        chk("pp3_instr_rvalid", instr_rvalid_o, 1);
        tick(); #2;
        chk("pp4_data_rvalid", data_rvalid_o, 1);
        chk("pp4_instr_rvalid", instr_rvalid_o, 0);
        tick(); idle();

        // Reset mid-operation with one transaction outstanding.
        data_req_i = 1'b1; data_addr_i = 32'h500; mem_gnt_i = 1'b1; #2;
        chk("rm_data_gnt", data_gnt_o, 1);
        tick();
        mem_rvalid_i = 1'b1; rst_ni = 1'b0; #2;
        chk("rm_mem_req", mem_req_o, 0);
        chk("rm_data_gnt0", data_gnt_o, 0);
        chk("rm_data_rvalid", data_rvalid_o, 0);
        chk("rm_mem_addr", mem_addr_o, 0);
        rst_ni = 1'b1; idle();
        mem_rvalid_i = 1'b1; #2;
        chk("rm_late_data_rvalid", data_rvalid_o, 0);
        chk("rm_late_instr_rvalid", instr_rvalid_o, 0);
        tick(); idle();

        // Continuous contention right after reset, one pop per cycle after the first.
        instr_req_i = 1'b1; instr_addr_i = 32'h600;
        data_req_i = 1'b1; data_addr_i = 32'h700; mem_gnt_i = 1'b1;
        prev_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef CVE2_OBI_ARB_RR_EN
            exp_data = (i % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            mem_rvalid_i = (i != 0); #2;
            chk($sformatf("ct%0d_data_gnt", i), data_gnt_o, exp_data);
            chk($sformatf("ct%0d_instr_gnt", i), instr_gnt_o, !exp_data);
            chk($sformatf("ct%0d_addr", i), mem_addr_o, exp_data ? 32'h700 : 32'h600);
            if (i != 0) chk($sformatf("ct%0d_data_rvalid", i), data_rvalid_o, prev_data);
            prev_data = exp_data;
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
